// File: rtl/spu_reg_fetch_pkg.sv
// Shared definitions for the SPU register-fetch/forward stage: register file
// geometry, state encodings and the bundle handed to the even execute pipe.
package spu_reg_fetch_pkg;

   localparam int NUM_REGS   = 128;
   localparam int REG_WIDTH  = 128;
   localparam int ADDR_WIDTH = 7;
   localparam int OP_WIDTH   = 11;
   localparam int FMT_WIDTH  = 3;
   localparam int IMM_WIDTH  = 18;
   localparam int NUM_READS  = 3;

   // Clear/run state encodings kept as plain constants for legacy tools.
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Big-endian vectors: bit 0 is the most significant bit.
   typedef logic [0:REG_WIDTH-1]  reg_data_t;
   typedef logic [0:ADDR_WIDTH-1] reg_addr_t;
   typedef logic [0:OP_WIDTH-1]   opcode_t;
   typedef logic [0:IMM_WIDTH-1]  imm_t;

   // Everything the execute unit consumes in one cycle.
   typedef struct packed {
      opcode_t                op;
      logic [FMT_WIDTH-1:0]   format;
      reg_addr_t              rt_addr;
      reg_data_t              ra;
      reg_data_t              rb;
      reg_data_t              rc;
      imm_t                   imm;
      logic                   reg_write;
   } exec_bundle_t;

   // Bundle issued for empty slots and while the register file is being cleared.
   localparam exec_bundle_t NOP_BUNDLE = '{
      op:        '0,
      format:    '0,
      rt_addr:   '0,
      ra:        '0,
      rb:        '0,
      rc:        '0,
      imm:       '0,
      reg_write: 1'b0
   };

   // True when both write-back pipes target the same register in one cycle.
   function automatic logic same_addr_collision(
      input logic      even_we,
      input reg_addr_t even_addr,
      input logic      odd_we,
      input reg_addr_t odd_addr
   );
      return even_we && odd_we && (even_addr == odd_addr);
   endfunction

endpackage

// File: rtl/spu_reg_fetch_if.sv
// Decode, write-back and execute-bundle signals of the register-fetch stage.
// The slave side is the fetch stage itself; the master side is its environment.
interface spu_reg_fetch_if;
   import spu_reg_fetch_pkg::*;

   // Decoded instruction from the issue stage.
   logic                   dec_valid;
   opcode_t                op_in;
   logic [FMT_WIDTH-1:0]   format_in;
   reg_addr_t              rt_addr_in;
   reg_addr_t              ra_addr;
   reg_addr_t              rb_addr;
   reg_addr_t              rc_addr;
   imm_t                   imm_in;
   logic                   reg_write_in;

   // Write-back from the even and odd pipes.
   reg_data_t              rt_wb_even;
   reg_addr_t              rt_addr_wb_even;
   logic                   reg_write_wb_even;
   reg_data_t              rt_wb_odd;
   reg_addr_t              rt_addr_wb_odd;
   logic                   reg_write_wb_odd;

   // Registered bundle to the even execute pipe plus status.
   opcode_t                op;
   logic [FMT_WIDTH-1:0]   format;
   reg_addr_t              rt_addr;
   reg_data_t              ra;
   reg_data_t              rb;
   reg_data_t              rc;
   imm_t                   imm;
   logic                   reg_write;
   logic                   init_busy;
   logic                   wr_collision;

   modport slave (
      input  dec_valid, op_in, format_in, rt_addr_in,
      input  ra_addr, rb_addr, rc_addr, imm_in, reg_write_in,
      input  rt_wb_even, rt_addr_wb_even, reg_write_wb_even,
      input  rt_wb_odd, rt_addr_wb_odd, reg_write_wb_odd,
      output op, format, rt_addr, ra, rb, rc, imm, reg_write,
      output init_busy, wr_collision
   );

   modport master (
      output dec_valid, op_in, format_in, rt_addr_in,
      output ra_addr, rb_addr, rc_addr, imm_in, reg_write_in,
      output rt_wb_even, rt_addr_wb_even, reg_write_wb_even,
      output rt_wb_odd, rt_addr_wb_odd, reg_write_wb_odd,
      input  op, format, rt_addr, ra, rb, rc, imm, reg_write,
      input  init_busy, wr_collision
   );

endinterface

// File: rtl/spu_rf_bypass.sv
// Three-port read-with-bypass mux. Each read port independently picks the odd
// write-back, then the even write-back, then the stored array value.
module spu_rf_bypass
   import spu_reg_fetch_pkg::*;
(
   input  reg_addr_t rd_addr  [NUM_READS],
   input  reg_data_t arr_data [NUM_READS],
   input  reg_data_t even_data,
   input  reg_addr_t even_addr,
   input  logic      even_we,
   input  reg_data_t odd_data,
   input  reg_addr_t odd_addr,
   input  logic      odd_we,
   output reg_data_t rd_data  [NUM_READS]
);

   // Odd pipe wins so a same-cycle read matches what the array will store.
   always_comb begin
      for (int i = 0; i < NUM_READS; i++) begin
         rd_data[i] = arr_data[i];
         if (odd_we && (odd_addr == rd_addr[i])) begin
            rd_data[i] = odd_data;
         end else if (even_we && (even_addr == rd_addr[i])) begin
            rd_data[i] = even_data;
         end
      end
   end

endmodule

// File: rtl/spu_reg_fetch.sv
// SPU register-fetch/forward stage: 128 x 128-bit register file, post-reset
// clear sequence, three bypassed operand reads and the registered execute bundle.
module spu_reg_fetch
   import spu_reg_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   spu_reg_fetch_if.slave  bus
);

   logic [0:0]   state;
   reg_addr_t    clr_cnt;
   reg_data_t    mem [NUM_REGS];
   exec_bundle_t bundle_q;
   logic         collision_q;

   reg_addr_t    rd_addr  [NUM_READS];
   reg_data_t    arr_data [NUM_READS];
   reg_data_t    rd_data  [NUM_READS];

   logic         running;
   logic         collision_now;

   assign running       = (state == ST_RUN);
   assign collision_now = same_addr_collision(bus.reg_write_wb_even, bus.rt_addr_wb_even,
                                              bus.reg_write_wb_odd,  bus.rt_addr_wb_odd);

   assign rd_addr[0] = bus.ra_addr;
   assign rd_addr[1] = bus.rb_addr;
   assign rd_addr[2] = bus.rc_addr;

   // Raw array reads, one per operand port.
   always_comb begin
      for (int i = 0; i < NUM_READS; i++) begin
         arr_data[i] = mem[rd_addr[i]];
      end
   end

   spu_rf_bypass u_bypass (
      .rd_addr   (rd_addr),
      .arr_data  (arr_data),
      .even_data (bus.rt_wb_even),
      .even_addr (bus.rt_addr_wb_even),
      .even_we   (bus.reg_write_wb_even),
      .odd_data  (bus.rt_wb_odd),
      .odd_addr  (bus.rt_addr_wb_odd),
      .odd_we    (bus.reg_write_wb_odd),
      .rd_data   (rd_data)
   );

   // Clear sequencer: walk every entry once after reset, then run until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else if (state == ST_INIT) begin
         clr_cnt <= clr_cnt + reg_addr_t'(1);
         if (clr_cnt == reg_addr_t'(NUM_REGS - 1)) begin
            state <= ST_RUN;
         end
      end
   end

   // Register file writes: zeros while clearing, write-backs once running.
   // The odd port is written last so it owns a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
         end else begin
            if (bus.reg_write_wb_even) begin
               mem[bus.rt_addr_wb_even] <= bus.rt_wb_even;
            end
            if (bus.reg_write_wb_odd) begin
               mem[bus.rt_addr_wb_odd] <= bus.rt_wb_odd;
            end
         end
      end
   end

   // Execute bundle and collision flag, one cycle behind the decode inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         bundle_q    <= NOP_BUNDLE;
         collision_q <= 1'b0;
      end else begin
         collision_q <= running && collision_now;
         if (running && bus.dec_valid) begin
            bundle_q.op        <= bus.op_in;
            bundle_q.format    <= bus.format_in;
            bundle_q.rt_addr   <= bus.rt_addr_in;
            bundle_q.ra        <= rd_data[0];
            bundle_q.rb        <= rd_data[1];
            bundle_q.rc        <= rd_data[2];
            bundle_q.imm       <= bus.imm_in;
            bundle_q.reg_write <= bus.reg_write_in;
         end else begin
            bundle_q <= NOP_BUNDLE;
         end
      end
   end

   assign bus.op           = bundle_q.op;
   assign bus.format       = bundle_q.format;
   assign bus.rt_addr      = bundle_q.rt_addr;
   assign bus.ra           = bundle_q.ra;
   assign bus.rb           = bundle_q.rb;
   assign bus.rc           = bundle_q.rc;
   assign bus.imm          = bundle_q.imm;
   assign bus.reg_write    = bundle_q.reg_write;
   assign bus.init_busy    = (state == ST_INIT);
   assign bus.wr_collision = collision_q;

endmodule

// File: tb/tb_spu_reg_fetch.sv
// Directed bench for spu_reg_fetch: clear sequence, write-back, bypass,
// collision, field pass-through and mid-stream reset.
module tb_spu_reg_fetch;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   busy;
   logic init_leak;

   localparam logic [127:0] P1   = {32{4'h1}};
   localparam logic [127:0] P2   = {32{4'h2}};
   localparam logic [127:0] PA   = {32{4'hA}};
   localparam logic [127:0] P5   = {32{4'h5}};
   localparam logic [127:0] PF   = {32{4'hF}};
   localparam logic [127:0] ZERO = 128'd0;

   spu_reg_fetch_if bus ();

   spu_reg_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Drive all stage inputs idle.
   task automatic clearInputs();
      bus.dec_valid         = 1'b0;
      bus.op_in             = '0;
      bus.format_in         = '0;
      bus.rt_addr_in        = '0;
      bus.ra_addr           = '0;
      bus.rb_addr           = '0;
      bus.rc_addr           = '0;
      bus.imm_in            = '0;
      bus.reg_write_in      = 1'b0;
      bus.rt_wb_even        = '0;
      bus.rt_addr_wb_even   = '0;
      bus.reg_write_wb_even = 1'b0;
      bus.rt_wb_odd         = '0;
      bus.rt_addr_wb_odd    = '0;
      bus.reg_write_wb_odd  = 1'b0;
   endtask

   // Count cycles with init_busy high, bounded; optional drops during INIT.
   task automatic countInit(input logic inject, output int cycles, output logic leak);
      cycles = 0;
      leak   = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!bus.init_busy) break;
         cycles++;
         if (bus.op != '0 || bus.ra != '0 || bus.reg_write || bus.wr_collision) leak = 1'b1;
         if (inject && cycles == 2) begin
            bus.rt_wb_even        = PF;
            bus.rt_addr_wb_even   = 7'd5;
            bus.reg_write_wb_even = 1'b1;
            bus.rt_wb_odd         = P2;
            bus.rt_addr_wb_odd    = 7'd5;
            bus.reg_write_wb_odd  = 1'b1;
         end else begin
            bus.reg_write_wb_even = 1'b0;
            bus.reg_write_wb_odd  = 1'b0;
         end
         applyStimulus();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      clearInputs();
      repeat (3) applyStimulus();

      checkOutput("rst_init_busy", 128'(bus.init_busy), 128'd1);
      checkOutput("rst_op", 128'(bus.op), ZERO);
      checkOutput("rst_ra", bus.ra, ZERO);
      checkOutput("rst_reg_write", 128'(bus.reg_write), ZERO);
      checkOutput("rst_collision", 128'(bus.wr_collision), ZERO);

      // Release reset; keep a valid instruction reading r5 during the clear.
      reset         = 1'b0;
      bus.dec_valid = 1'b1;
      bus.op_in     = 11'h7FF;
      bus.ra_addr   = 7'd5;
      bus.reg_write_in = 1'b1;
      countInit(1'b1, busy, init_leak);
      checkOutput("init_len", 128'(busy), 128'd128);
      checkOutput("init_outputs_nop", 128'(init_leak), ZERO);
      checkOutput("init_last_op", 128'(bus.op), ZERO);

      // r5 write during INIT must have been dropped.
      clearInputs();
      bus.dec_valid = 1'b1;
      bus.ra_addr   = 7'd5;
      applyStimulus();
      checkOutput("r5_dropped", bus.ra, ZERO);
      checkOutput("run_busy", 128'(bus.init_busy), ZERO);

      // Even r10 and odd r4, different addresses.
      clearInputs();
      bus.rt_wb_even = P1; bus.rt_addr_wb_even = 7'd10; bus.reg_write_wb_even = 1'b1;
      bus.rt_wb_odd  = P5; bus.rt_addr_wb_odd  = 7'd4;  bus.reg_write_wb_odd  = 1'b1;
      applyStimulus();
      checkOutput("no_collision", 128'(bus.wr_collision), ZERO);

      clearInputs();
      bus.dec_valid = 1'b1;
      bus.ra_addr   = 7'd10;
      bus.rb_addr   = 7'd4;
      applyStimulus();
      checkOutput("r10_read", bus.ra, P1);
      checkOutput("r4_read", bus.rb, P5);
      checkOutput("r0_read", bus.rc, ZERO);

      // Same-cycle even bypass on aliased reads.
      clearInputs();
      bus.rt_wb_even = PA; bus.rt_addr_wb_even = 7'd3; bus.reg_write_wb_even = 1'b1;
      bus.dec_valid  = 1'b1;
      bus.ra_addr    = 7'd3;
      bus.rb_addr    = 7'd3;
      bus.rc_addr    = 7'd4;
      applyStimulus();
      checkOutput("byp_even_ra", bus.ra, PA);
      checkOutput("byp_even_rb", bus.rb, PA);
      checkOutput("byp_array_rc", bus.rc, P5);

      // Collision on r7: odd data wins, bypass and array both agree.
      clearInputs();
      bus.rt_wb_even = P1; bus.rt_addr_wb_even = 7'd7; bus.reg_write_wb_even = 1'b1;
      bus.rt_wb_odd  = P2; bus.rt_addr_wb_odd  = 7'd7; bus.reg_write_wb_odd  = 1'b1;
      bus.dec_valid  = 1'b1;
      bus.ra_addr    = 7'd7;
      bus.rb_addr    = 7'd3;
      bus.rc_addr    = 7'd10;
      applyStimulus();
      checkOutput("coll_pulse", 128'(bus.wr_collision), 128'd1);
      checkOutput("coll_byp_ra", bus.ra, P2);
      checkOutput("coll_r3_array", bus.rb, PA);
      checkOutput("coll_r10_array", bus.rc, P1);

      clearInputs();
      bus.dec_valid = 1'b1;
      bus.ra_addr   = 7'd7;
      applyStimulus();
      checkOutput("coll_pulse_end", 128'(bus.wr_collision), ZERO);
      checkOutput("coll_r7_stored", bus.ra, P2);

      // Field pass-through.
      clearInputs();
      bus.dec_valid    = 1'b1;
      bus.op_in        = 11'b00011000000;
      bus.format_in    = 3'd0;
      bus.rt_addr_in   = 7'd9;
      bus.imm_in       = 18'h003FF;
      bus.reg_write_in = 1'b1;
      bus.ra_addr      = 7'd10;
      applyStimulus();
      checkOutput("fld_op", 128'(bus.op), 128'h0C0);
      checkOutput("fld_format", 128'(bus.format), ZERO);
      checkOutput("fld_rt_addr", 128'(bus.rt_addr), 128'd9);
      checkOutput("fld_imm", 128'(bus.imm), 128'h3FF);
      checkOutput("fld_reg_write", 128'(bus.reg_write), 128'd1);
      checkOutput("fld_ra", bus.ra, P1);

      bus.op_in     = 11'h7FF;
      bus.format_in = 3'b101;
      bus.imm_in    = 18'h20001;
      applyStimulus();
      checkOutput("fld2_op", 128'(bus.op), 128'h7FF);
      checkOutput("fld2_format", 128'(bus.format), 128'd5);
      checkOutput("fld2_imm", 128'(bus.imm), 128'h20001);

      // dec_valid low gives the nop bundle even with live addresses.
      bus.dec_valid = 1'b0;
      applyStimulus();
      checkOutput("nop_op", 128'(bus.op), ZERO);
      checkOutput("nop_rt_addr", 128'(bus.rt_addr), ZERO);
      checkOutput("nop_imm", 128'(bus.imm), ZERO);
      checkOutput("nop_reg_write", 128'(bus.reg_write), ZERO);
      checkOutput("nop_ra", bus.ra, ZERO);

      // Mid-stream reset with a colliding write-back pair present.
      bus.dec_valid = 1'b1;
      bus.rt_wb_even = P1; bus.rt_addr_wb_even = 7'd12; bus.reg_write_wb_even = 1'b1;
      bus.rt_wb_odd  = P2; bus.rt_addr_wb_odd  = 7'd12; bus.reg_write_wb_odd  = 1'b1;
      reset = 1'b1;
      applyStimulus();
      checkOutput("mid_rst_busy", 128'(bus.init_busy), 128'd1);
      checkOutput("mid_rst_op", 128'(bus.op), ZERO);
      checkOutput("mid_rst_ra", bus.ra, ZERO);
      checkOutput("mid_rst_reg_write", 128'(bus.reg_write), ZERO);
      checkOutput("mid_rst_collision", 128'(bus.wr_collision), ZERO);

      reset = 1'b0;
      clearInputs();
      countInit(1'b0, busy, init_leak);
      checkOutput("reinit_len", 128'(busy), 128'd128);
      checkOutput("reinit_outputs_nop", 128'(init_leak), ZERO);

      bus.dec_valid = 1'b1;
      bus.ra_addr   = 7'd10;
      bus.rb_addr   = 7'd7;
      bus.rc_addr   = 7'd3;
      applyStimulus();
      checkOutput("cleared_r10", bus.ra, ZERO);
      checkOutput("cleared_r7", bus.rb, ZERO);
      checkOutput("cleared_r3", bus.rc, ZERO);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
